// File: rtl/arith_addsub_pipe_if.sv
// Operand/result bus of the pipelined add/subtract unit.
// The master side presents operands and consumes results.
// The slave side is the arithmetic unit itself.
interface arith_addsub_pipe_if #(
  parameter int WIDTH = 18
);

  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [1:0]       op;
  logic             cin;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;

  modport master (
    output in_valid, op1, op2, op, cin, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
  );

  modport slave (
    input  in_valid, op1, op2, op, cin, out_ready,
    output in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
  );

endinterface

// File: rtl/arith_addsub_pipe.sv
// Two-stage pipelined add/subtract unit with carry-in, status flags,
// optional signed saturation and valid/ready flow control.
// The carry chain is split at LO_W: the low half is summed in stage 1,
// the high half, overflow, saturation and flags in stage 2.
// Opcodes: 00 ADD a+b, 01 SUB a-b, 10 ADC a+b+cin, 11 SBC a+~b+cin.
module arith_addsub_pipe #(
  parameter int WIDTH    = 18,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  arith_addsub_pipe_if.slave   bus
);

  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  // Largest positive or most negative value, chosen by the sign of operand A.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    logic [WIDTH-1:0] v;
    if (neg) begin
      v = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      v = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return v;
  endfunction

  // Signed overflow: operands share a sign and the raw sum does not.
  function automatic logic overflow(input logic a_msb, input logic b_msb,
                                    input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic adv_s;
  logic out_valid_r;

  // The whole pipeline steps when the output slot is empty or being drained.
  assign adv_s = !out_valid_r || bus.out_ready;

  // ---------------------------------------------------------------------
  // Operand preparation and low-half sum
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] b_prep_s;
  logic             c0_s;
  logic [LO_W-1:0]  lo_s;
  logic             c_lo_s;

  // Invert B for subtracting opcodes and pick the carry into bit 0.
  always_comb begin
    b_prep_s = bus.op2;
    c0_s     = 1'b0;
    if (bus.op[0]) begin
      b_prep_s = ~bus.op2;
    end else begin
      b_prep_s = bus.op2;
    end
    case (bus.op)
      2'b00:   c0_s = 1'b0;
      2'b01:   c0_s = 1'b1;
      2'b10:   c0_s = bus.cin;
      2'b11:   c0_s = bus.cin;
      default: c0_s = 1'b0;
    endcase
  end

  // Low half of the carry chain, finished within stage 1.
  always_comb begin
    {c_lo_s, lo_s} = {1'b0, bus.op1[LO_W-1:0]}
                   + {1'b0, b_prep_s[LO_W-1:0]}
                   + {{LO_W{1'b0}}, c0_s};
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  logic            s1_valid_r;
  logic [LO_W-1:0] s1_lo_r;
  logic            s1_c_lo_r;
  logic [HI_W-1:0] s1_a_hi_r;
  logic [HI_W-1:0] s1_b_hi_r;

  // Capture the low-half sum and the high-half operands on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_lo_r    <= {LO_W{1'b0}};
      s1_c_lo_r  <= 1'b0;
      s1_a_hi_r  <= {HI_W{1'b0}};
      s1_b_hi_r  <= {HI_W{1'b0}};
    end else if (adv_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_lo_r   <= lo_s;
        s1_c_lo_r <= c_lo_s;
        s1_a_hi_r <= bus.op1[WIDTH-1:LO_W];
        s1_b_hi_r <= b_prep_s[WIDTH-1:LO_W];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: high half, overflow, saturation, flags
  // ---------------------------------------------------------------------
  logic [HI_W-1:0]  hi_s;
  logic             c_hi_s;
  logic [WIDTH-1:0] raw_s;
  logic             v_s;
  logic [WIDTH-1:0] res_s;
  logic             z_s;
  logic             n_s;

  // High half of the carry chain, fed by the registered low-half carry.
  always_comb begin
    {c_hi_s, hi_s} = {1'b0, s1_a_hi_r}
                   + {1'b0, s1_b_hi_r}
                   + {{HI_W{1'b0}}, s1_c_lo_r};
  end

  // Assemble the raw sum, detect overflow and clamp when saturating.
  always_comb begin
    raw_s = {hi_s, s1_lo_r};
    v_s   = overflow(s1_a_hi_r[HI_W-1], s1_b_hi_r[HI_W-1], raw_s[WIDTH-1]);
    if (SATURATE && v_s) begin
      res_s = sat_value(s1_a_hi_r[HI_W-1]);
    end else begin
      res_s = raw_s;
    end
  end

  // Zero and negative flags describe the final (possibly clamped) result.
  always_comb begin
    if (res_s == {WIDTH{1'b0}}) begin
      z_s = 1'b1;
    end else begin
      z_s = 1'b0;
    end
    n_s = res_s[WIDTH-1];
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] result_r;
  logic             flag_c_r;
  logic             flag_v_r;
  logic             flag_z_r;
  logic             flag_n_r;

  // Move stage-1 work into the output slot; hold everything while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      flag_c_r    <= 1'b0;
      flag_v_r    <= 1'b0;
      flag_z_r    <= 1'b0;
      flag_n_r    <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= res_s;
        flag_c_r <= c_hi_s;
        flag_v_r <= v_s;
        flag_z_r <= z_s;
        flag_n_r <= n_s;
      end
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flag_c    = flag_c_r;
  assign bus.flag_v    = flag_v_r;
  assign bus.flag_z    = flag_z_r;
  assign bus.flag_n    = flag_n_r;

endmodule

// File: tb/tb_arith_addsub_pipe.sv
// Directed and randomised checks of arith_addsub_pipe at WIDTH=18.
// Two instances (wrapping and saturating) receive identical stimulus.
module tb_arith_addsub_pipe;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  arith_addsub_pipe_if #(.WIDTH(18)) if_w ();
  arith_addsub_pipe_if #(.WIDTH(18)) if_s ();

  arith_addsub_pipe #(.WIDTH(18), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .bus(if_w.slave));
  arith_addsub_pipe #(.WIDTH(18), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .bus(if_s.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [17:0] a, input logic [17:0] b,
                       input logic [1:0] o, input logic ci);
    if_w.in_valid = v; if_w.op1 = a; if_w.op2 = b; if_w.op = o; if_w.cin = ci;
    if_s.in_valid = v; if_s.op1 = a; if_s.op2 = b; if_s.op = o; if_s.cin = ci;
  endtask

  task automatic set_ready(input logic r);
    if_w.out_ready = r;
    if_s.out_ready = r;
  endtask

  function automatic logic [3:0] flags_w();
    return {if_w.flag_c, if_w.flag_v, if_w.flag_z, if_w.flag_n};
  endfunction

  function automatic logic [3:0] flags_s();
    return {if_s.flag_c, if_s.flag_v, if_s.flag_z, if_s.flag_n};
  endfunction

  // Reference: {c, v, z, n, result} computed on the full 19-bit sum.
  function automatic logic [21:0] model(input logic [17:0] a, input logic [17:0] b,
                                        input logic [1:0] o, input logic ci,
                                        input logic sat);
    logic [17:0] bp;
    logic        c0;
    logic [18:0] full;
    logic [17:0] res;
    logic        v;
    bp   = o[0] ? ~b : b;
    c0   = o[1] ? ci : o[0];
    full = {1'b0, a} + {1'b0, bp} + {18'd0, c0};
    v    = (a[17] == bp[17]) && (full[17] != a[17]);
    res  = (sat && v) ? (a[17] ? 18'h20000 : 18'h1FFFF) : full[17:0];
    return {full[18], v, (res == 18'd0), res[17], res};
  endfunction

  // One operation through an otherwise empty pipe, both variants checked.
  task automatic run_op(input string tag, input logic [17:0] a, input logic [17:0] b,
                        input logic [1:0] o, input logic ci,
                        input logic [17:0] ew, input logic [3:0] fw,
                        input logic [17:0] es, input logic [3:0] fs);
    int n;
    drive(1'b1, a, b, o, ci);
    tick();
    drive(1'b0, 18'd0, 18'd0, OP_ADD, 1'b0);
    n = 0;
    while (!if_w.out_valid && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, if_w.out_valid}, 32'd1);
    chk({tag, "_res_w"}, {14'd0, if_w.result}, {14'd0, ew});
    chk({tag, "_flg_w"}, {28'd0, flags_w()}, {28'd0, fw});
    chk({tag, "_res_s"}, {14'd0, if_s.result}, {14'd0, es});
    chk({tag, "_flg_s"}, {28'd0, flags_s()}, {28'd0, fs});
    tick();
  endtask

  initial begin
    logic [17:0] exp_q_w[$];
    logic [17:0] exp_q_s[$];
    logic [3:0]  fq_w[$];
    logic [3:0]  fq_s[$];
    logic [21:0] m;
    logic [17:0] held;
    logic        held_ok;
    int          sent;
    int          got;

    drive(1'b0, 18'd0, 18'd0, OP_ADD, 1'b0);
    set_ready(1'b1);

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", {31'd0, if_w.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, if_w.in_ready},  32'd1);
    chk("rst_result",    {14'd0, if_w.result},    32'd0);
    chk("rst_flags",     {28'd0, flags_w()},      32'd0);
    reset = 1'b0;
    tick();

    // 1: ADD 1+2, result appears on the second edge after presentation
    drive(1'b1, 18'h00001, 18'h00002, OP_ADD, 1'b0);
    tick();
    drive(1'b0, 18'd0, 18'd0, OP_ADD, 1'b0);
    chk("t1_lat_e1", {31'd0, if_w.out_valid}, 32'd0);
    tick();
    chk("t1_lat_e2", {31'd0, if_w.out_valid}, 32'd1);
    chk("t1_res",    {14'd0, if_w.result},    32'h3);
    chk("t1_flags",  {28'd0, flags_w()},      32'h0);
    tick();
    chk("t1_drained", {31'd0, if_w.out_valid}, 32'd0);

    // 2: carry out and carry in
    run_op("t2_add_wrap", 18'h3FFFF, 18'h00001, OP_ADD, 1'b0,
           18'h00000, 4'b1010, 18'h00000, 4'b1010);
    run_op("t2_adc", 18'h00000, 18'h00000, OP_ADC, 1'b1,
           18'h00001, 4'b0000, 18'h00001, 4'b0000);

    // 3: positive overflow, wrap vs saturate
    run_op("t3_pos_ovf", 18'h1FFFF, 18'h00001, OP_ADD, 1'b0,
           18'h20000, 4'b0101, 18'h1FFFF, 4'b0100);
    // negative overflow: most negative minus one
    run_op("t3_neg_ovf", 18'h20000, 18'h00001, OP_SUB, 1'b0,
           18'h1FFFF, 4'b1100, 18'h20000, 4'b1101);

    // 4: borrow semantics
    run_op("t4_sub_borrow", 18'h00000, 18'h00001, OP_SUB, 1'b0,
           18'h3FFFF, 4'b0001, 18'h3FFFF, 4'b0001);
    run_op("t4_sub_eq", 18'h00005, 18'h00005, OP_SUB, 1'b0,
           18'h00000, 4'b1010, 18'h00000, 4'b1010);
    run_op("t4_sbc", 18'h00005, 18'h00005, OP_SBC, 1'b0,
           18'h3FFFF, 4'b0001, 18'h3FFFF, 4'b0001);
    // ADD ignores cin
    run_op("t4_add_cin", 18'h00010, 18'h00020, OP_ADD, 1'b1,
           18'h00030, 4'b0000, 18'h00030, 4'b0000);

    // 5: six back-to-back ADDs with a three-cycle consumer stall
    sent = 0;
    got  = 0;
    held = 18'd0;
    held_ok = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      set_ready(!(c >= 4 && c < 7));
      drive(sent < 6, 18'(sent + 1), 18'(sent + 1), OP_ADD, 1'b0);
      #1;
      if (if_w.out_valid && !if_w.out_ready) begin
        chk("t5_stall_in_ready", {31'd0, if_w.in_ready}, 32'd0);
        if (held_ok) chk("t5_stall_hold", {14'd0, if_w.result}, {14'd0, held});
        held    = if_w.result;
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (if_w.out_valid && if_w.out_ready) begin
        chk("t5_stream_res", {14'd0, if_w.result}, 32'(2 * (got + 1)));
        got++;
      end
      if (if_w.in_valid && if_w.in_ready) sent++;
      tick();
    end
    chk("t5_stream_count", 32'(got), 32'd6);
    drive(1'b0, 18'd0, 18'd0, OP_ADD, 1'b0);
    set_ready(1'b1);
    tick();
    chk("t5_no_dup", {31'd0, if_w.out_valid}, 32'd0);

    // 5b: random in_valid/out_ready soak against the reference model
    for (int c = 0; c < 400; c++) begin
      logic [17:0] a;
      logic [17:0] b;
      logic [1:0]  o;
      logic        ci;
      a  = ($urandom_range(0, 3) == 0) ? 18'h1FFFF : 18'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 18'h00001 : 18'($urandom);
      o  = 2'($urandom_range(0, 3));
      ci = 1'($urandom_range(0, 1));
      set_ready($urandom_range(0, 2) != 0);
      drive(1'($urandom_range(0, 1)), a, b, o, ci);
      #1;
      if (if_w.out_valid && if_w.out_ready) begin
        if (exp_q_w.size() == 0) begin
          chk("soak_unexpected", {31'd0, if_w.out_valid}, 32'd0);
        end else begin
          chk("soak_res_w", {14'd0, if_w.result}, {14'd0, exp_q_w.pop_front()});
          chk("soak_flg_w", {28'd0, flags_w()},   {28'd0, fq_w.pop_front()});
          chk("soak_res_s", {14'd0, if_s.result}, {14'd0, exp_q_s.pop_front()});
          chk("soak_flg_s", {28'd0, flags_s()},   {28'd0, fq_s.pop_front()});
        end
      end
      if (if_w.in_valid && if_w.in_ready) begin
        m = model(a, b, o, ci, 1'b0);
        exp_q_w.push_back(m[17:0]);
        fq_w.push_back(m[21:18]);
        m = model(a, b, o, ci, 1'b1);
        exp_q_s.push_back(m[17:0]);
        fq_s.push_back(m[21:18]);
      end
      tick();
    end
    drive(1'b0, 18'd0, 18'd0, OP_ADD, 1'b0);
    set_ready(1'b1);
    for (int c = 0; c < 10 && exp_q_w.size() > 0; c++) begin
      #1;
      if (if_w.out_valid) begin
        chk("drain_res_w", {14'd0, if_w.result}, {14'd0, exp_q_w.pop_front()});
        chk("drain_flg_w", {28'd0, flags_w()},   {28'd0, fq_w.pop_front()});
        chk("drain_res_s", {14'd0, if_s.result}, {14'd0, exp_q_s.pop_front()});
        chk("drain_flg_s", {28'd0, flags_s()},   {28'd0, fq_s.pop_front()});
      end
      tick();
    end
    chk("soak_all_out", 32'(exp_q_w.size()), 32'd0);

    // 6: reset with two operations in flight
    tick();
    drive(1'b1, 18'h00100, 18'h00200, OP_ADD, 1'b0);
    tick();
    drive(1'b1, 18'h00300, 18'h00400, OP_ADD, 1'b0);
    tick();
    drive(1'b0, 18'd0, 18'd0, OP_ADD, 1'b0);
    chk("t6_inflight", {31'd0, if_w.out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid",  {31'd0, if_w.out_valid}, 32'd0);
    chk("t6_rst_result", {14'd0, if_w.result},    32'd0);
    chk("t6_rst_flags",  {28'd0, flags_w()},      32'd0);
    chk("t6_rst_ready",  {31'd0, if_w.in_ready},  32'd1);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t6_no_stale", {31'd0, if_w.out_valid}, 32'd0);
    run_op("t6_post", 18'h00007, 18'h00003, OP_SUB, 1'b0,
           18'h00004, 4'b1000, 18'h00004, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
